// File: rtl/s2_bitplane_store.sv
`default_nettype none
// ============================================================================
// Module   : s2_bitplane_store
// Purpose  : S2 end of the S1 link. Stores eight 18-bit bit-plane frames in
//            RB2, then returns the 18 original bytes as 13-bit packets.
// Revision : 1.0  initial release
// ============================================================================
module s2_bitplane_store (
    input  logic        clk,
    input  logic        rst,
    input  logic        updown,
    output logic        S2_done,
    output logic        RB2_RW,
    output logic [2:0]  RB2_A,
    output logic [17:0] RB2_D,
    input  logic [17:0] RB2_Q,
    inout  wire         sen,
    inout  wire         sd
);

    typedef enum logic [2:0] {
        RX_WAIT  = 3'd0,
        RX_SHIFT = 3'd1,
        RX_WR    = 3'd2,
        WAIT_UP  = 3'd3,
        RD       = 3'd4,
        TX_BIT   = 3'd5,
        TX_GAP   = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t      state;
    logic [20:0] shreg;
    logic [4:0]  bit_cnt;
    logic [3:0]  frame_cnt;
    logic [17:0] plane [8];
    logic [4:0]  pkt_idx;
    logic [3:0]  bit_idx;
    logic        sen_oe;
    logic        sen_out;
    logic        sd_oe;
    logic        sd_out;

    logic [7:0]  cur_byte;
    logic [12:0] pkt_word;
    logic [4:0]  next_pkt;

    // Byte j is spread across the planes: bit b lives in plane[b][j].
    always_comb begin
        cur_byte = '0;
        for (int b = 0; b < 8; b++) begin
            cur_byte[b] = plane[b][pkt_idx];
        end
    end

    assign pkt_word = {pkt_idx, cur_byte};
    assign next_pkt = pkt_idx + 5'd1;

    // The link is only ever driven during the upload phase.
    assign sen = (sen_oe && updown) ? sen_out : 1'bz;
    assign sd  = (sd_oe  && updown) ? sd_out  : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_WAIT;
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            pkt_idx   <= '0;
            bit_idx   <= '0;
            RB2_RW    <= 1'b1;
            RB2_A     <= '0;
            RB2_D     <= '0;
            S2_done   <= 1'b0;
            sen_oe    <= 1'b0;
            sen_out   <= 1'b1;
            sd_oe     <= 1'b0;
            sd_out    <= 1'b0;
            for (int p = 0; p < 8; p++) begin
                plane[p] <= '0;
            end
        end else begin
            case (state)
                RX_WAIT, RX_SHIFT, RX_WR: begin
                    RB2_RW <= 1'b1;
                    if (state == RX_WR && frame_cnt == 4'd8) begin
                        state <= WAIT_UP;
                    end else if (sen == 1'b0) begin
                        shreg <= {shreg[19:0], sd};
                        if (bit_cnt != 5'd31) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        state <= RX_SHIFT;
                    end else begin
                        bit_cnt <= '0;
                        if (bit_cnt == 5'd21) begin
                            RB2_A     <= shreg[20:18];
                            RB2_D     <= shreg[17:0];
                            RB2_RW    <= 1'b0;
                            frame_cnt <= frame_cnt + 4'd1;
                            state     <= RX_WR;
                        end else begin
                            state <= RX_WAIT;
                        end
                    end
                end
                WAIT_UP: begin
                    if (updown) begin
                        state <= RD;
                        RB2_A <= '0;
                    end
                end
                RD: begin
                    plane[RB2_A] <= RB2_Q;
                    if (RB2_A == 3'd7) begin
                        // First bit of packet 0 is its index MSB, always 0.
                        state   <= TX_BIT;
                        pkt_idx <= '0;
                        bit_idx <= 4'd12;
                        sen_oe  <= 1'b1;
                        sen_out <= 1'b0;
                        sd_oe   <= 1'b1;
                        sd_out  <= 1'b0;
                    end else begin
                        RB2_A <= RB2_A + 3'd1;
                    end
                end
                TX_BIT: begin
                    if (bit_idx != 4'd0) begin
                        bit_idx <= bit_idx - 4'd1;
                        sd_out  <= pkt_word[bit_idx - 4'd1];
                    end else begin
                        state   <= TX_GAP;
                        sen_out <= 1'b1;
                        sd_oe   <= 1'b0;
                    end
                end
                TX_GAP: begin
                    if (pkt_idx == 5'd17) begin
                        state   <= DONE;
                        S2_done <= 1'b1;
                    end else begin
                        pkt_idx <= next_pkt;
                        bit_idx <= 4'd12;
                        sen_out <= 1'b0;
                        sd_oe   <= 1'b1;
                        sd_out  <= next_pkt[4];
                        state   <= TX_BIT;
                    end
                end
                DONE: begin
                    S2_done <= 1'b1;
                end
                default: begin
                    state <= RX_WAIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s2_bitplane_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2_bitplane_store
// Purpose  : Scoreboard bench for s2_bitplane_store with an S1 link driver,
//            an RB2 memory and a byte-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_s2_bitplane_store;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        updown = 1'b0;
    logic        S2_done;
    logic        RB2_RW;
    logic [2:0]  RB2_A;
    logic [17:0] RB2_D;
    logic [17:0] RB2_Q;
    tri1         sen;
    tri0         sd;

    logic s1_en  = 1'b0;
    logic s1_sen = 1'b1;
    logic s1_sd  = 1'b0;
    assign sen = s1_en ? s1_sen : 1'bz;
    assign sd  = s1_en ? s1_sd  : 1'bz;

    logic [17:0] rb2 [8] = '{default: '0};
    always @(posedge clk) if (RB2_RW == 1'b0) rb2[RB2_A] <= RB2_D;
    assign RB2_Q = rb2[RB2_A];

    s2_bitplane_store dut (
        .clk     (clk),
        .rst     (rst),
        .updown  (updown),
        .S2_done (S2_done),
        .RB2_RW  (RB2_RW),
        .RB2_A   (RB2_A),
        .RB2_D   (RB2_D),
        .RB2_Q   (RB2_Q),
        .sen     (sen),
        .sd      (sd)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [20:0] exp_wr [$];
    logic [12:0] exp_pkt [$];
    logic [7:0]  model_bytes [18];
    logic [7:0]  det_bytes [18];
    bit          up_mon = 1'b0;
    logic [12:0] pk     = '0;
    int          pk_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: RB2 write strobes and upload packets against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            pk_cnt = 0;
        end else begin
            if (RB2_RW == 1'b0) begin
                if (exp_wr.size() == 0) check("stray_write", 32'({RB2_A, RB2_D}), 32'hFFFF_FFFF);
                else check("rb2_write", 32'({RB2_A, RB2_D}), 32'(exp_wr.pop_front()));
            end
            if (up_mon) begin
                if (sen == 1'b0) begin
                    pk = {pk[11:0], sd};
                    pk_cnt++;
                end else if (pk_cnt != 0) begin
                    if (exp_pkt.size() == 0) check("stray_packet", 32'(pk), 32'hFFFF_FFFF);
                    else check("tx_packet", {15'(pk_cnt), 4'd0, pk}, {15'd13, 4'd0, exp_pkt.pop_front()});
                    pk_cnt = 0;
                end
            end
        end
    end

    function automatic logic [17:0] det_plane(input int p);
        logic [17:0] d;
        for (int k = 0; k < 18; k++) d[k] = det_bytes[k][p];
        return d;
    endfunction

    task automatic send_frame(input logic [2:0] p, input logic [17:0] d, input int nbits, input int gap);
        logic [20:0] v;
        v = {p, d};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            s1_sen = 1'b0;
            s1_sd  = (i < 21) ? v[20-i] : 1'($urandom);
        end
        @(negedge clk);
        s1_sen = 1'b1;
        s1_sd  = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic valid_frame(input logic [2:0] p, input logic [17:0] d, input int gap);
        exp_wr.push_back({p, d});
        for (int k = 0; k < 18; k++) model_bytes[k][p] = d[k];
        send_frame(p, d, 21, gap);
    endtask

    task automatic random_download();
        int valid;
        valid = 0;
        while (valid < 8) begin
            int nb;
            if ($urandom_range(0, 3) == 0) begin
                nb = $urandom_range(1, 60);
                if (nb == 21) nb = 22;
                send_frame(3'($urandom), 18'($urandom), nb, $urandom_range(1, 3));
            end
            valid_frame(3'($urandom), 18'($urandom), (valid == 7) ? 1 : $urandom_range(1, 3));
            valid++;
        end
    endtask

    // Called right after the last frame's boundary has been set up.
    task automatic finish_and_upload(input bit abort);
        updown = 1'b1;
        @(posedge clk); #1 s1_en = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("write_count", 32'(exp_wr.size()), 32'd0);
        check("rd_start", 32'({RB2_RW, RB2_A}), 32'({1'b1, 3'd0}));
        for (int j = 0; j < 18; j++) exp_pkt.push_back({5'(j), model_bytes[j]});
        up_mon = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            @(posedge clk); #1;
            if (c <= 7) check("rd_addr", 32'({RB2_RW, RB2_A}), 32'({1'b1, 3'(c)}));
            if (abort && c == 140) begin
                check("sen_tx_low", 32'(sen), 32'd0);
                rst = 1'b1;
                #1;
                check("sen_release", 32'(sen), 32'd1);
                check("sd_release", 32'(sd), 32'd0);
                check("rst_done", 32'(S2_done), 32'd0);
                check("rst_addr", 32'({RB2_RW, RB2_A}), 32'({1'b1, 3'd0}));
                @(negedge clk);
                exp_pkt.delete();
                up_mon = 1'b0;
                updown = 1'b0;
                s1_en  = 1'b1;
                s1_sen = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (c == 259) check("done_early", 32'(S2_done), 32'd0);
            if (c == 260) check("done", 32'(S2_done), 32'd1);
        end
        check("pkt_count", 32'(exp_pkt.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("done_sticky", 32'({S2_done, sen}), 32'h3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 18; k++) begin
            model_bytes[k] = '0;
            det_bytes[k]   = 8'(13 * k + 5);
        end

        repeat (2) @(negedge clk);
        #1;
        check("rst_rw_a", 32'({RB2_RW, RB2_A}), 32'({1'b1, 3'd0}));
        check("rst_d", 32'(RB2_D), 32'd0);
        check("rst_done", 32'(S2_done), 32'd0);
        check("rst_link", 32'({sen, sd}), 32'({1'b1, 1'b0}));
        @(negedge clk);
        rst    = 1'b0;
        s1_en  = 1'b1;
        s1_sen = 1'b1;
        repeat (6) @(negedge clk);

        // Run 1: known byte pattern, short and over-long frames, early updown.
        valid_frame(3'd0, det_plane(0), 1);
        valid_frame(3'd1, det_plane(1), 2);
        valid_frame(3'd2, det_plane(2), 1);
        send_frame(3'd3, det_plane(3), 20, 1);
        send_frame(3'd3, det_plane(3), 53, 2);
        valid_frame(3'd3, det_plane(3), 1);
        valid_frame(3'd4, det_plane(4), 1);
        updown = 1'b1;
        repeat (5) @(negedge clk);
        check("no_early_rd", 32'({RB2_RW, RB2_A}), 32'({1'b1, 3'd4}));
        check("no_early_link", 32'(sen), 32'd1);
        valid_frame(3'd5, det_plane(5), 1);
        valid_frame(3'd6, det_plane(6), 3);
        valid_frame(3'd7, det_plane(7), 1);
        finish_and_upload(1'b0);

        // Run 2: random download, reset in the middle of packet 9.
        @(negedge clk);
        rst    = 1'b1;
        up_mon = 1'b0;
        updown = 1'b0;
        s1_en  = 1'b1;
        s1_sen = 1'b1;
        @(negedge clk);
        #1 check("rst2_done", 32'(S2_done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        random_download();
        finish_and_upload(1'b1);

        // Run 3: fresh random download and complete upload after the abort.
        repeat (3) @(negedge clk);
        random_download();
        finish_and_upload(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s2_bitplane_store.md
# s2_bitplane_store

Receiving and returning stage on the far side of the S1 serial link. It collects the eight bit-plane packets that S1 sends over `sen`/`sd` and writes them into the 8x18 buffer RB2. When `updown` rises, it reads RB2 back, re-forms the original 18 bytes and returns them to S1 as 18 byte packets. It raises `S2_done` when the last packet has gone out.

## Interface
- Parameters: none. Frame widths and RB2 geometry are fixed: 8 words x 18 bits, 21-bit rx frame, 13-bit tx frame.
- `clk` input 1: single clock. All S2 state changes on rising edge; S1 drives the link on falling edge.
- `rst` input 1: reset, asynchronous and active-high.
- `updown` input 1: 0 = download phase (S1→S2), 1 = upload phase (S2→S1).
- `S2_done` output 1: high once all 18 upload packets are sent; sticky until reset.
- `RB2_RW` output 1: 1 = read, 0 = write. RB2 writes `RB2_D` at `RB2_A` on the rising edge where `RB2_RW`=0.
- `RB2_A` output 3: RB2 word address (bit-plane index).
- `RB2_D` output 18: RB2 write data. Bit k is bit p of byte k.
- `RB2_Q` input 18: RB2 read data, combinational from `RB2_A`.
- `sen` inout 1: frame enable. Low = bit slot, high = frame boundary/idle.
- `sd` inout 1: serial data.

## Operation
- States: RX_WAIT, RX_SHIFT, RX_WR, WAIT_UP, RD, TX_BIT, TX_GAP, DONE.
- Download, rx frame = 21 bits, MSB first: `addr[2:0]`, then data for byte 17 down to byte 0.
- At each posedge with `sen`=0:
  - shift `sd` into a 21-bit shift register;
  - increment the bit count, saturating at 31.
- At a posedge with `sen`=1 after shifting:
  - If count==21: go to RX_WR. Register `RB2_A`=addr, `RB2_D`=data bits (byte 17 in bit 17), `RB2_RW`=0 for exactly one cycle. Increment the frame counter.
  - If count≠21: discard the frame, no write, frame counter unchanged.
  - Either way, clear the count.
- After the 8th valid frame's write: enter WAIT_UP, `RB2_RW`=1.
- `updown` is ignored in every state except WAIT_UP.
- Duplicate plane addresses are allowed; the last write wins. The frame counter still counts 8 frames.
- WAIT_UP → RD on the first posedge with `updown`=1.
- RD, 8 cycles:
  - `RB2_A` = 0..7, `RB2_RW`=1;
  - each cycle, capture `RB2_Q` into `plane[RB2_A]`.
- Upload, tx packet j = 0..17, 13 bits, MSB first: `j[4:0]`, then byte bits 7..0. Byte j bit b = `plane[b][j]`.
- TX_BIT: S2 drives `sen`=0 and `sd`=current bit, 13 cycles.
- TX_GAP: S2 drives `sen`=1 and releases `sd`, 1 cycle.
- After the gap of packet 17: DONE, `S2_done`=1, keep driving `sen`=1.
- Tri-state rules:
  - S2 drives `sen` only in TX_BIT, TX_GAP and DONE; high-Z otherwise.
  - S2 drives `sd` only in TX_BIT.
- S2 never drives the link while `updown`=0.

## Timing
- Reset values: `S2_done`=0, `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `sen`/`sd` high-Z. All counters 0, state RX_WAIT.
- Rx sampling is on posedge. This is the centre of S1's negedge-driven bit.
- Write latency: the first posedge seeing `sen`=1 registers the write outputs. RB2 commits on the next posedge. `RB2_RW` returns to 1 one cycle later.
- A new frame may start (`sen`=0) in the cycle right after the boundary. Its first bit is shifted while RX_WR is active, and the write is not delayed.
- Upload start: `updown` seen high → RD for 8 cycles. The first TX_BIT cycle immediately follows the 8th capture.
- Per packet: 14 cycles (13 bits + 1 gap). Full upload = 8 + 18×14 = 260 cycles from RD entry to DONE.
- `S2_done` rises one cycle after the last TX_GAP.
- Reset mid-operation, asynchronous:
  - `sen`/`sd` go to high-Z immediately;
  - partial frames and counters are lost;
  - RB2 contents are not cleared.

## Test plan
- Reset check: assert `rst` at t=0 → `S2_done`=0, `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `sen`/`sd`=Z. No write strobes while `sen` is idle.
- Download: send 8 frames for bytes `byte[k]` = 8'(13k+5), planes 0..7 in order → exactly 8 write pulses. RB2[p] bit k = `byte[k][p]`, e.g. RB2[0] bit 0 = 1 (byte0=0x05). State ends in WAIT_UP.
- Short frame: a 20-bit frame on plane 3, then a valid plane-3 frame → one write only, with the valid data. The frame counter still needs 8 valid frames.
- Early `updown`: raise `updown` after 5 frames → no RD. Finish the 3 remaining frames → RD starts on the next posedge.
- Upload: from the download data, `updown`=1 →
  - `RB2_A` sweeps 0..7 with `RB2_RW`=1;
  - packet 0 = 00000_00000101, packet 17 = 10001_{byte17};
  - `sen` low 13 cycles / high 1 cycle per packet;
  - `S2_done`=1 at cycle 260 from RD entry.
- Reset mid-upload: pulse `rst` during packet 9 → `sen`/`sd` Z the same cycle. A fresh download plus upload then completes normally with `S2_done`=1.
